dbg_piso_tx: RTL and testbench
==============================

// Module: dbg_piso_tx
// PURPOSE
//  Debug parallel-in/serial-out transmitter; the far end of the 1-bit-per-slice debug SIPO link.
//  Snapshots a wide internal debug word and streams it LSB-slice first over ODAT_B pins.
//  oena marks slice 0, so the SIPO receiver can restart its slice counter on it.
//  Frames go out back-to-back and the held word is re-sent when no new word is offered.
// PARAMETERS
//  IDAT_B  10               parallel debug word width
//  ODAT_B  1                serial slice width (pins)
//  NSL     ceil(IDAT_B/ODAT_B)  data slices per frame (derived)
//  OCNT_B  tflog2(NSL+1)    slice counter width (derived, same ceil-log2 function as the SIPO)
// PORTS
//  clk    in   1       clock
//  rst    in   1       synchronous active-low reset
//  ivld   in   1       new debug word offered
//  idat   in   IDAT_B  debug word, sampled when ivld&irdy
//  irdy   out  1       ready: next cycle starts a new frame
//  oena   out  1       frame start; high with slice 0 only
//  odat   out  ODAT_B  serial slice
// BEHAVIOUR
//  - Reset is synchronous, active-low on rst, clock clk.
//    While rst=0: state=IDLE, cnt=0, hold=0, oena=0, odat=0, irdy=0.
//    irdy goes high the first cycle after rst deasserts.
//  - oena and odat are registered. irdy is decoded from registered state only, never from ivld.
//  - Slices: slice k = hold[k*ODAT_B +: ODAT_B]. Bits above IDAT_B-1 in the last slice are sent as 0.
//  - FLEN = NSL (NSL+1 with the parity option). cnt runs 0..FLEN-1.
//  - IDLE: no word ever loaded. oena=0, odat=0, irdy=1.
//    On ivld: hold<=idat, go to SHIFT, cnt=0.
//  - SHIFT: each cycle drives slice cnt.
//    oena=1 iff cnt==0. cnt increments; irdy=1 iff cnt==FLEN-1.
//  - Frame boundary (SHIFT, cnt==FLEN-1):
//    - with ivld: hold<=idat; the next cycle is oena with slice 0 of the new word.
//    - without ivld: cnt wraps to 0 and the held word is re-sent (refresh).
//  - Latency: word accepted in cycle t -> oena and slice 0 in t+1 -> last slice in t+FLEN.
//  - ivld while irdy=0 is ignored and not stored. The source holds ivld until irdy.
//  - Frames are never shortened, and there are no gap cycles between frames.
//  - Reset mid-frame: output is truncated immediately and returns to IDLE.
//    The receiver resynchronises on the next oena.
//  - NSL+1 <= 2**OCNT_B is guaranteed by construction, so the receiver counter never aliases.
// CONFIGURATION
//  DBGPISO_PARITY_EN defined:
//   - FLEN = NSL+1.
//   - Extra trailing slice: bit0 = ^hold (even parity), other bits 0.
//   - The receiver must be sized (NSL+1)*ODAT_B wide.
//  DBGPISO_PARITY_EN undefined:
//   - FLEN = NSL, no trailing slice, no parity logic.
// TESTING (IDAT_B=10, ODAT_B=1 unless noted)
//  1. Reset held, then released with ivld=0 -> oena=0, odat=0, irdy=1 indefinitely.
//  2. ivld, idat=10'h2A5 at t -> t+1..t+10 odat = 1,0,1,0,0,1,0,1,0,1; oena only at t+1; irdy at t+10.
//  3. ivld low after (2) -> odat pattern repeats every 10 cycles, with oena at t+11, t+21.
//  4. ivld held with 10'h155 mid-frame -> ignored until irdy; new frame starts back-to-back after the boundary.
//  5. rst=0 at slice 4, then released -> oena/odat=0 and IDLE; the next word starts a clean frame.
//  6. IDAT_B=10, ODAT_B=4, idat=10'h3C7 -> slices 7, C, 3 (upper pad bits 0); 3-cycle frames.
//     With DBGPISO_PARITY_EN: 4th slice=1 (^10'h3C7=1).
//  Self-check: a SIPO-model receiver fed oena/odat must equal the accepted word after each frame.

Source files
------------

// File: rtl/dbg_piso_tx.sv
// Debug parallel-in/serial-out transmitter: streams a held word LSB-slice first, oena marks slice 0.
// Optional trailing even-parity slice when DBGPISO_PARITY_EN is defined.
module dbg_piso_tx #(
    parameter int IDAT_B = 10,
    parameter int ODAT_B = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ivld,
    input  logic [IDAT_B-1:0] idat,
    output logic              irdy,
    output logic              oena,
    output logic [ODAT_B-1:0] odat
);
    localparam int NSL = (IDAT_B + ODAT_B - 1) / ODAT_B;
`ifdef DBGPISO_PARITY_EN
    localparam int FLEN = NSL + 1;
`else
    localparam int FLEN = NSL;
`endif
    localparam int OCNT_B = (NSL + 1 > 1) ? $clog2(NSL + 1) : 1;
    localparam int FBITS  = FLEN * ODAT_B;
    localparam logic [OCNT_B-1:0] CNT_LAST = OCNT_B'(FLEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [OCNT_B-1:0]   cnt_q, cnt_d;
    logic [IDAT_B-1:0]   hold_q, hold_d;
    logic                oena_q, oena_d;
    logic [ODAT_B-1:0]   odat_q, odat_d;
    logic                irdy_q, irdy_d;
    logic                accept;
    logic [FBITS-1:0]    frame;
    logic [FBITS-1:0]    shifted;

    // Whole frame as one vector: data slices, zero pad, then the optional parity slice.
    function automatic logic [FBITS-1:0] build_frame(input logic [IDAT_B-1:0] w);
        logic [FBITS-1:0] f;
        f = '0;
        f[IDAT_B-1:0] = w;
`ifdef DBGPISO_PARITY_EN
        f[NSL*ODAT_B] = ^w;
`endif
        return f;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        oena_d  = 1'b0;
        odat_d  = '0;
        irdy_d  = 1'b0;
        frame   = '0;
        shifted = '0;
        accept  = ivld & irdy_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    hold_d  = idat;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // Frame boundary: either load the offered word or wrap and refresh the held one.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (accept) begin
                        hold_d = idat;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are computed from the next state so they appear registered with it.
        if (state_d == SHIFT) begin
            frame   = build_frame(hold_d);
            shifted = frame >> (int'(cnt_d) * ODAT_B);
            odat_d  = shifted[ODAT_B-1:0];
            oena_d  = (cnt_d == '0);
        end
        irdy_d = (state_d == IDLE) || (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            oena_q  <= 1'b0;
            odat_q  <= '0;
            irdy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            oena_q  <= oena_d;
            odat_q  <= odat_d;
            irdy_q  <= irdy_d;
        end
    end

    assign irdy = irdy_q;
    assign oena = oena_q;
    assign odat = odat_q;
endmodule

// File: tb/tb_dbg_piso_tx.sv
// Bench for dbg_piso_tx: 10x1 instance with a SIPO-model receiver and scoreboard, plus a 10x4 instance.
module tb_dbg_piso_tx;
`ifdef DBGPISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN0 = 10 + PAR;
    localparam int FLEN1 = 3 + PAR;

    logic       clk;
    logic       rst;
    logic       ivld;
    logic [9:0] idat;
    logic       irdy;
    logic       oena;
    logic [0:0] odat;
    logic       ivld1;
    logic [9:0] idat1;
    logic       irdy1;
    logic       oena1;
    logic [3:0] odat1;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    dbg_piso_tx #(.IDAT_B(10), .ODAT_B(1)) u_dut0 (
        .clk(clk), .rst(rst), .ivld(ivld), .idat(idat),
        .irdy(irdy), .oena(oena), .odat(odat)
    );

    dbg_piso_tx #(.IDAT_B(10), .ODAT_B(4)) u_dut1 (
        .clk(clk), .rst(rst), .ivld(ivld1), .idat(idat1),
        .irdy(irdy1), .oena(oena1), .odat(odat1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic int ones(input logic [9:0] w);
        int n = 0;
        for (int i = 0; i < 10; i++) n += int'(w[i]);
        return n;
    endfunction

    function automatic logic [3:0] exp_slice(input logic [9:0] w, input int k, input int ow);
        int nsl = (10 + ow - 1) / ow;
        if (k < nsl) return 4'((int'(w) / (1 << (k * ow))) % (1 << ow));
        return 4'(ones(w) % 2);
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] w);
        int n = 0;
        bit acc = 0;
        ivld = 1'b1;
        idat = w;
        while (!acc && n < FLEN0 + 1) begin
            acc = (irdy === 1'b1);
            tick();
            n++;
        end
        ivld = 1'b0;
        idat = 10'($urandom);
        if (acc) exp_q.push_back(w);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: word %h not accepted within %0d cycles", w, FLEN0 + 1);
        end
    endtask

    task automatic wait_oena();
        int n = 0;
        while (oena !== 1'b1 && n < FLEN0 + 2) begin
            tick();
            n++;
        end
        checks++;
        if (oena !== 1'b1) begin
            errors++;
            $display("FAIL wait_oena: oena=%b required 1", oena);
        end
    endtask

    // scoreboard: SIPO-model receiver on u_dut0
    initial begin
        bit in_frame;
        bit expect_start;
        int rx_n;
        logic [10:0] rx;
        logic [10:0] e;
        in_frame = 0;
        expect_start = 0;
        rx_n = 0;
        rx = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                in_frame = 0;
                expect_start = 0;
            end else begin
                if (expect_start) begin
                    expect_start = 0;
                    checks++;
                    if (oena !== 1'b1) begin
                        errors++;
                        $display("FAIL mon_gap: oena=%b after frame end, required 1", oena);
                    end
                end
                if (oena === 1'b1) begin
                    checks++;
                    if (in_frame) begin
                        errors++;
                        $display("FAIL mon_short: frame restarted after %0d slices, required %0d", rx_n, FLEN0);
                    end
                    while (exp_q.size() > 1) void'(exp_q.pop_front());
                    in_frame = 1;
                    rx_n = 0;
                    rx = '0;
                end
                if (in_frame) begin
                    rx[rx_n] = odat[0];
                    rx_n++;
                    if (rx_n == FLEN0) begin
                        in_frame = 0;
                        expect_start = 1;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL mon_word: frame %h received with no accepted word", rx);
                        end else begin
                            e = {1'b0, exp_q[0]};
                            if (PAR == 1) e[10] = 1'(ones(exp_q[0]) % 2);
                            if (rx !== e) begin
                                errors++;
                                $display("FAIL mon_word: received %h required %h", rx, e);
                            end
                        end
                    end
                end
            end
        end
    end

    // tests
    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (oena !== 1'b0 || odat !== 1'b0 || irdy !== 1'b0 || irdy1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: oena=%b odat=%b irdy=%b irdy1=%b required 0 0 0 0", oena, odat, irdy, irdy1);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idat = 10'($urandom);
            tick();
            checks++;
            if (oena !== 1'b0 || odat !== 1'b0 || irdy !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle: cyc %0d oena=%b odat=%b irdy=%b required 0 0 1", i, oena, odat, irdy);
            end
        end
    endtask

    task automatic test_basic();
        logic [9:0] w = 10'h2A5;
        logic [0:0] bits [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        send_word(w);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < FLEN0; k++) begin
                checks++;
                if (odat !== 1'(exp_slice(w, k, 1)) || oena !== (k == 0) || irdy !== (k == FLEN0 - 1)) begin
                    errors++;
                    $display("FAIL basic: frame %0d slice %0d odat=%b oena=%b irdy=%b required %b %b %b",
                             f, k, odat, oena, irdy, 1'(exp_slice(w, k, 1)), k == 0, k == FLEN0 - 1);
                end
                if (k < 10) begin
                    checks++;
                    if (odat !== bits[k]) begin
                        errors++;
                        $display("FAIL basic_table: slice %0d odat=%b required %b", k, odat, bits[k]);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_hold_midframe();
        logic [9:0] w_old = 10'h2A5;
        logic [9:0] w_new = 10'h155;
        wait_oena();
        repeat (3) tick();
        ivld = 1'b1;
        idat = w_new;
        for (int k = 3; k < FLEN0; k++) begin
            checks++;
            if (odat !== 1'(exp_slice(w_old, k, 1)) || oena !== 1'b0 || irdy !== (k == FLEN0 - 1)) begin
                errors++;
                $display("FAIL hold_old: slice %0d odat=%b oena=%b irdy=%b required %b 0 %b",
                         k, odat, oena, irdy, 1'(exp_slice(w_old, k, 1)), k == FLEN0 - 1);
            end
            tick();
        end
        ivld = 1'b0;
        exp_q.push_back(w_new);
        for (int k = 0; k < FLEN0; k++) begin
            checks++;
            if (odat !== 1'(exp_slice(w_new, k, 1)) || oena !== (k == 0)) begin
                errors++;
                $display("FAIL hold_new: slice %0d odat=%b oena=%b required %b %b",
                         k, odat, oena, 1'(exp_slice(w_new, k, 1)), k == 0);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] w;
        for (int i = 0; i < 16; i++) begin
            w = 10'($urandom);
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(0, 2 * FLEN0)) tick();
            send_word(w);
            checks++;
            if (oena !== 1'b1 || odat !== 1'(exp_slice(w, 0, 1))) begin
                errors++;
                $display("FAIL b2b_start: word %h oena=%b odat=%b required 1 %b", w, oena, odat, 1'(exp_slice(w, 0, 1)));
            end
        end
        repeat (2 * FLEN0) tick();
    endtask

    task automatic test_reset_midframe();
        logic [9:0] w;
        wait_oena();
        repeat (4) tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        checks++;
        if (oena !== 1'b0 || odat !== 1'b0 || irdy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: oena=%b odat=%b irdy=%b required 0 0 0", oena, odat, irdy);
        end
        rst = 1'b1;
        for (int i = 0; i < 2 * FLEN0; i++) begin
            tick();
            checks++;
            if (oena !== 1'b0 || odat !== 1'b0 || irdy !== 1'b1) begin
                errors++;
                $display("FAIL rst_idle: cyc %0d oena=%b odat=%b irdy=%b required 0 0 1", i, oena, odat, irdy);
            end
        end
        w = 10'($urandom);
        send_word(w);
        for (int k = 0; k < FLEN0; k++) begin
            checks++;
            if (odat !== 1'(exp_slice(w, k, 1)) || oena !== (k == 0)) begin
                errors++;
                $display("FAIL rst_clean: slice %0d odat=%b oena=%b required %b %b",
                         k, odat, oena, 1'(exp_slice(w, k, 1)), k == 0);
            end
            tick();
        end
    endtask

    task automatic test_wide();
        logic [9:0] w = 10'h3C7;
        logic [3:0] tbl [4] = '{4'h7, 4'hC, 4'h3, 4'h1};
        checks++;
        if (irdy1 !== 1'b1) begin
            errors++;
            $display("FAIL wide_rdy: irdy1=%b required 1", irdy1);
        end
        ivld1 = 1'b1;
        idat1 = w;
        tick();
        ivld1 = 1'b0;
        idat1 = 10'($urandom);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FLEN1; k++) begin
                checks++;
                if (odat1 !== tbl[k] || odat1 !== exp_slice(w, k, 4) || oena1 !== (k == 0) || irdy1 !== (k == FLEN1 - 1)) begin
                    errors++;
                    $display("FAIL wide: frame %0d slice %0d odat1=%h oena1=%b irdy1=%b required %h %b %b",
                             f, k, odat1, oena1, irdy1, tbl[k], k == 0, k == FLEN1 - 1);
                end
                tick();
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        ivld = 1'b0;
        idat = '0;
        ivld1 = 1'b0;
        idat1 = '0;
        test_reset();
        test_basic();
        test_hold_midframe();
        test_back_to_back();
        test_reset_midframe();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
